// File: rtl/fft_pkg.sv
// Shared constants, frame FSM state type and the sideband record that travels with each beat
// through the FFT peak detector pipeline.
package fft_pkg;
    localparam int N         = 8192;
    localparam int DW        = 16;
    localparam int IW        = $clog2(N);
    localparam int MW        = 2 * DW;
    localparam int EW        = 6;
    localparam int SEARCH_LO = 1;
    localparam int SEARCH_HI = N / 2 - 1;

    typedef enum logic {IDLE, FRAME} state_t;

    typedef struct packed {
        logic          valid;
        logic          sop;
        logic          eop;
        logic          err;
        logic [IW-1:0] bin;
        logic [EW-1:0] blk_exp;
    } meta_t;

    function automatic logic in_search(input logic [IW-1:0] bin);
        return (bin >= IW'(SEARCH_LO)) && (bin <= IW'(SEARCH_HI));
    endfunction
endpackage

// File: rtl/fft_mag_sq.sv
// Datapath stages 1-3 of the peak detector: input register, signed squares, unsigned sum.
// The frame sideband is delayed alongside so it lines up with the magnitude.
module fft_mag_sq
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    input  meta_t                i_meta,
    output logic [MW-1:0]        o_mag,
    output meta_t                o_meta
);
    logic [1:0][DW-1:0] w_comp;
    logic [1:0][MW-1:0] w_sq;
    meta_t              r_s1_meta;
    meta_t              r_s2_meta;
    meta_t              r_s3_meta;
    logic [MW-1:0]      r_s3_mag;

    assign w_comp = {i_im, i_re};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sq
            logic signed [DW-1:0] r_s1_comp;
            logic signed [MW-1:0] r_s2_sq;

            // Operands sign-extended first so the product is a full-width signed square.
            always_ff @(posedge clk) begin
                r_s1_comp <= w_comp[gi];
                r_s2_sq   <= MW'(r_s1_comp) * MW'(r_s1_comp);
            end

            assign w_sq[gi] = r_s2_sq;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_meta <= '0;
            r_s2_meta <= '0;
            r_s3_meta <= '0;
            r_s3_mag  <= '0;
        end else begin
            r_s1_meta <= i_meta;
            r_s2_meta <= r_s1_meta;
            r_s3_meta <= r_s2_meta;
            r_s3_mag  <= w_sq[0] + w_sq[1];
        end
    end

    assign o_mag  = r_s3_mag;
    assign o_meta = r_s3_meta;
endmodule

// File: rtl/fft_peak_detect.sv
// FFT peak detector top: frame FSM, bin counter, exponent latch, compare stage and result registers.
// Define FFT_PEAK_FRAME_CHK_EN to enable malformed-frame reporting on frame_err.
module fft_peak_detect
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 source_valid,
    input  logic                 source_sop,
    input  logic                 source_eop,
    input  logic signed [DW-1:0] source_real,
    input  logic signed [DW-1:0] source_imag,
    input  logic [EW-1:0]        source_exp,
    output logic                 source_ready,
    output logic                 peak_valid,
    output logic [IW-1:0]        peak_index,
    output logic [MW-1:0]        peak_mag,
    output logic [EW-1:0]        peak_exp,
    output logic                 frame_err
);
    localparam logic [IW-1:0] BIN_LAST = IW'(N - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_ready;
    logic [IW-1:0] r_bin;
    logic [EW-1:0] r_exp;
    logic [IW-1:0] w_bin_inc;
    logic          w_accept;
    meta_t         w_meta;

    assign w_accept  = source_valid && r_ready;
    assign w_bin_inc = (r_bin == BIN_LAST) ? r_bin : r_bin + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_bin   <= '0;
            r_exp   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= 1'b1;
            if (w_meta.valid) begin
                r_bin <= w_meta.bin;
                r_exp <= w_meta.blk_exp;
            end
        end
    end

    // A sop always (re)starts a frame; other beats only count while a frame is open.
    always_comb begin
        w_state_next = r_state;
        w_meta       = '0;
        if (w_accept && (source_sop || r_state == FRAME)) begin
            w_meta.valid   = 1'b1;
            w_meta.sop     = source_sop;
            w_meta.eop     = source_eop;
            w_meta.bin     = source_sop ? '0 : w_bin_inc;
            w_meta.blk_exp = source_sop ? source_exp : r_exp;
            w_state_next   = source_eop ? IDLE : FRAME;
`ifdef FFT_PEAK_FRAME_CHK_EN
            if (source_sop)
                w_meta.err = (r_state == FRAME) || source_eop;
            else if (source_eop)
                w_meta.err = (w_bin_inc != BIN_LAST);
            else
                w_meta.err = (w_bin_inc == BIN_LAST) && (r_bin != BIN_LAST);
`endif
        end
    end

    logic [MW-1:0] w_mag;
    meta_t         w_mag_meta;

    fft_mag_sq u_mag_sq (
        .clk    (clk),
        .rst    (rst),
        .i_re   (source_real),
        .i_im   (source_imag),
        .i_meta (w_meta),
        .o_mag  (w_mag),
        .o_meta (w_mag_meta)
    );

    logic [MW-1:0] r_max_mag;
    logic [IW-1:0] r_max_idx;
    logic [MW-1:0] w_base_mag;
    logic [IW-1:0] w_base_idx;
    logic [MW-1:0] w_upd_mag;
    logic [IW-1:0] w_upd_idx;
    logic          r_peak_valid;
    logic [IW-1:0] r_peak_index;
    logic [MW-1:0] r_peak_mag;
    logic [EW-1:0] r_peak_exp;
    logic          r_frame_err;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_base_mag = w_mag_meta.sop ? '0 : r_max_mag;
        w_base_idx = w_mag_meta.sop ? IW'(SEARCH_LO) : r_max_idx;
        w_upd_mag  = w_base_mag;
        w_upd_idx  = w_base_idx;
        if (in_search(w_mag_meta.bin) && (w_mag > w_base_mag)) begin
            w_upd_mag = w_mag;
            w_upd_idx = w_mag_meta.bin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_mag    <= '0;
            r_max_idx    <= IW'(SEARCH_LO);
            r_peak_valid <= 1'b0;
            r_peak_index <= '0;
            r_peak_mag   <= '0;
            r_peak_exp   <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_peak_valid <= w_mag_meta.valid && w_mag_meta.eop;
            r_frame_err  <= w_mag_meta.valid && w_mag_meta.err;
            if (w_mag_meta.valid) begin
                r_max_mag <= w_upd_mag;
                r_max_idx <= w_upd_idx;
                if (w_mag_meta.eop) begin
                    r_peak_index <= w_upd_idx;
                    r_peak_mag   <= w_upd_mag;
                    r_peak_exp   <= w_mag_meta.blk_exp;
                end
            end
        end
    end

    // Without frame checking the err flag is never set, so frame_err stays 0.
    assign source_ready = r_ready;
    assign peak_valid   = r_peak_valid;
    assign peak_index   = r_peak_index;
    assign peak_mag     = r_peak_mag;
    assign peak_exp     = r_peak_exp;
    assign frame_err    = r_frame_err;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: table-driven sparse spectra, randomized frames against a reference
// model, plus hand sequences for frame restart, mid-frame reset and back-to-back frames.
`timescale 1ns/1ps
module tb_fft_peak_detect;
    import fft_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 source_valid = 1'b0;
    logic                 source_sop = 1'b0;
    logic                 source_eop = 1'b0;
    logic signed [DW-1:0] source_real = '0;
    logic signed [DW-1:0] source_imag = '0;
    logic [EW-1:0]        source_exp = '0;
    logic                 source_ready;
    logic                 peak_valid;
    logic [IW-1:0]        peak_index;
    logic [MW-1:0]        peak_mag;
    logic [EW-1:0]        peak_exp;
    logic                 frame_err;

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk          (clk),
        .rst          (rst),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_exp   (source_exp),
        .source_ready (source_ready),
        .peak_valid   (peak_valid),
        .peak_index   (peak_index),
        .peak_mag     (peak_mag),
        .peak_exp     (peak_exp),
        .frame_err    (frame_err)
    );

    typedef struct { int idx; longint mag; int ex; longint cyc; } res_t;
    typedef struct {
        int b0, r0, i0, b1, r1, i1, b2, r2, i2;
        int e;
        int want_idx;
        longint want_mag;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc_n = 0;
    longint last_eop_cyc = 0;
    longint last_sop_cyc = 0;
    longint last_ferr_cyc = -1;
    int     ferr_cnt = 0;
    int     ferr_base = 0;
    int     got_rd = 0;
    res_t   got_q[$];
    res_t   exp_q[$];
    int     fr_re[N];
    int     fr_im[N];
    vec_t   vt[4];

    // Negedge monitor: every cycle gets an id; results and error pulses are logged against it.
    always @(negedge clk) begin
        res_t r;
        cyc_n = cyc_n + 1;
        if (peak_valid) begin
            r.idx = int'(peak_index);
            r.mag = longint'(peak_mag);
            r.ex  = int'(peak_exp);
            r.cyc = cyc_n;
            got_q.push_back(r);
        end
        if (frame_err) begin
            ferr_cnt      = ferr_cnt + 1;
            last_ferr_cyc = cyc_n;
        end
    end

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic idle(input int n);
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit sop, input bit eop, input int re, input int im, input int e);
        source_valid = 1'b1;
        source_sop   = sop;
        source_eop   = eop;
        source_real  = 16'(re);
        source_imag  = 16'(im);
        source_exp   = sop ? 6'(e) : 6'($urandom);
        if (eop) last_eop_cyc = cyc_n + 1;
        if (sop) last_sop_cyc = cyc_n + 1;
        @(posedge clk);
        #1;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input bit sop_first, input bit eop_last,
                              input int e, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 7) == 0) idle(1);
            beat(sop_first && b == 0, eop_last && b == nbeats - 1, fr_re[b], fr_im[b], e);
        end
    endtask

    task automatic clear_frame();
        for (int b = 0; b < N; b++) begin
            fr_re[b] = 0;
            fr_im[b] = 0;
        end
    endtask

    task automatic put(input int b, input int re, input int im);
        if (b >= 0) begin
            fr_re[b] = re;
            fr_im[b] = im;
        end
    endtask

    task automatic push_expect(input int idx, input longint mag, input int e, input longint cyc);
        res_t r;
        r.idx = idx;
        r.mag = mag;
        r.ex  = e;
        r.cyc = cyc;
        exp_q.push_back(r);
    endtask

    // Reference: brute-force maximum of re^2+im^2 over the search window, first index wins.
    task automatic model_expect(input int e, input longint cyc);
        longint best = 0;
        int     best_idx = SEARCH_LO;
        for (int b = SEARCH_LO; b <= SEARCH_HI; b++) begin
            longint m = longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
            if (m > best) begin
                best     = m;
                best_idx = b;
            end
        end
        push_expect(best_idx, best, e, cyc);
    endtask

    task automatic compare_results(input string nm, input int want_ferr);
        res_t g, w;
        int   n_got;
        idle(10);
        n_got = got_q.size() - got_rd;
        check({nm, " result_count"}, n_got, exp_q.size());
        for (int k = 0; k < n_got && k < exp_q.size(); k++) begin
            g = got_q[got_rd + k];
            w = exp_q[k];
            $display("%s: got idx=%0d mag=%0d exp=%0d cyc=%0d | want idx=%0d mag=%0d exp=%0d cyc=%0d",
                     nm, g.idx, g.mag, g.ex, g.cyc, w.idx, w.mag, w.ex, w.cyc);
            check({nm, " peak_index"}, g.idx, w.idx);
            check({nm, " peak_mag"}, g.mag, w.mag);
            check({nm, " peak_exp"}, g.ex, w.ex);
            check({nm, " latency_cycle"}, g.cyc, w.cyc);
        end
        got_rd = got_q.size();
        exp_q.delete();
        check({nm, " frame_err_pulses"}, ferr_cnt - ferr_base, want_ferr);
        ferr_base = ferr_cnt;
    endtask

    initial begin
        longint restart_cyc;
        longint spacing;

        vt[0] = '{100, 300, -400, -1, 0, 0, -1, 0, 0, 5, 100, 64'd250000};
        vt[1] = '{0, 32767, 0, 5000, 32767, 0, 20, 10, 10, 33, 20, 64'd200};
        vt[2] = '{30, -1000, 0, 40, -1000, 0, -1, 0, 0, 63, 30, 64'd1000000};
        vt[3] = '{7, -32768, -32768, -1, 0, 0, -1, 0, 0, 32, 7, 64'h8000_0000};

        idle(4);
        check("reset source_ready", source_ready, 0);
        check("reset peak_valid", peak_valid, 0);
        check("reset peak_index", peak_index, 0);
        check("reset peak_mag", peak_mag, 0);
        check("reset peak_exp", peak_exp, 0);
        check("reset frame_err", frame_err, 0);
        rst = 1'b0;
        idle(1);
        check("ready after reset", source_ready, 1);

        // Beats without sop while idle must be ignored, including an eop.
        beat(0, 0, 20000, 0, 0);
        beat(0, 1, 20000, 0, 0);
        idle(2);

        for (int t = 0; t < 4; t++) begin
            clear_frame();
            put(vt[t].b0, vt[t].r0, vt[t].i0);
            put(vt[t].b1, vt[t].r1, vt[t].i1);
            put(vt[t].b2, vt[t].r2, vt[t].i2);
            send_frame(N, 1, 1, vt[t].e, 1);
            push_expect(vt[t].want_idx, vt[t].want_mag, vt[t].e, last_eop_cyc + 4);
            compare_results($sformatf("vec%0d", t), 0);
        end

        // Frame restarted by a sop at bin 50; only the second frame may report.
        clear_frame();
        put(10, 30000, 0);
        send_frame(50, 1, 0, 11, 0);
        clear_frame();
        put(9, 123, 45);
        send_frame(N, 1, 1, 12, 0);
        restart_cyc = last_sop_cyc;
        push_expect(9, 17154, 12, last_eop_cyc + 4);
`ifdef FFT_PEAK_FRAME_CHK_EN
        compare_results("restart", 1);
        check("restart frame_err cycle", last_ferr_cyc, restart_cyc + 4);
`else
        compare_results("restart", 0);
`endif

        // One-cycle reset in the middle of a frame; the rest of that frame must be dropped.
        clear_frame();
        put(50, 1000, 1000);
        put(200, 20000, 0);
        send_frame(150, 1, 0, 20, 0);
        rst          = 1'b1;
        source_valid = 1'b1;
        source_real  = 16'sd5000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset source_ready low", source_ready, 0);
        check("midreset peak_index cleared", peak_index, 0);
        @(posedge clk);
        #1;
        source_valid = 1'b0;
        check("midreset source_ready back", source_ready, 1);
        for (int b = 151; b < 300; b++) beat(0, b == 299, fr_re[b], fr_im[b], 0);
        compare_results("midreset", 0);

        // Back-to-back randomized frames, the second with small values to force ties.
        for (int b = 0; b < N; b++) begin
            fr_re[b] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[b] = int'($urandom_range(0, 65535)) - 32768;
        end
        send_frame(N, 1, 1, 40, 0);
        model_expect(40, last_eop_cyc + 4);
        for (int b = 0; b < N; b++) begin
            fr_re[b] = int'($urandom_range(0, 15)) - 8;
            fr_im[b] = int'($urandom_range(0, 15)) - 8;
        end
        put(300, -20, 0);
        put(700, 0, 20);
        put(0, 30000, 0);
        put(6000, 100, 0);
        send_frame(N, 1, 1, 41, 0);
        model_expect(41, last_eop_cyc + 4);
        compare_results("b2b", 0);
        if (got_q.size() >= 2) begin
            spacing = got_q[got_q.size() - 1].cyc - got_q[got_q.size() - 2].cyc;
            check("b2b result spacing", spacing, N);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
